// File: rtl/mem_arb_pkg.sv
// Shared constants for the instruction/data memory arbiter: FSM encodings,
// default access latency and the grant-side encoding used by the round-robin flag.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam int unsigned MEM_LATENCY_DEFAULT = 2;
    localparam int          CNT_W               = 4;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin tie-break: a lone requester always wins; on a tie the side
// opposite to last_grant wins. Purely combinational.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant_d
);

    assign grant_d = req_d & (~req_i | (last_grant == GRANT_I));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a shared single-port memory between instruction and data requesters.
// Each access holds the memory for MEM_LATENCY cycles, then one IDLE bubble follows.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEFAULT
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_out
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               last_grant, last_grant_nxt;
    logic [31:0]        addr_q, addr_nxt;
    logic [31:0]        wdata_q, wdata_nxt;
    logic               we_q, we_nxt;
    logic               grant_d;
    logic               busy;
    logic               final_cyc;

    rr_pick2 u_pick (
        .req_i      (i_req),
        .req_d      (d_req),
        .last_grant (last_grant),
        .grant_d    (grant_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= GRANT_I;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_grant <= last_grant_nxt;
            addr_q     <= addr_nxt;
            wdata_q    <= wdata_nxt;
            we_q       <= we_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        last_grant_nxt = last_grant;
        addr_nxt       = addr_q;
        wdata_nxt      = wdata_q;
        we_nxt         = we_q;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt      = BUSY_D;
                    addr_nxt       = d_addr;
                    we_nxt         = d_we;
                    wdata_nxt      = d_wdata;
                    cnt_nxt        = LAT_M1;
                    last_grant_nxt = GRANT_D;
                end else if (i_req) begin
                    state_nxt      = BUSY_I;
                    addr_nxt       = i_addr;
                    we_nxt         = 1'b0;
                    wdata_nxt      = '0;
                    cnt_nxt        = LAT_M1;
                    last_grant_nxt = GRANT_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are masked by reset so an aborted access never writes or pulses ready.
    assign busy      = ((state == BUSY_I) || (state == BUSY_D)) && !reset;
    assign final_cyc = busy && (cnt == '0);

    assign mem_addr  = busy ? addr_q  : '0;
    assign mem_din   = busy ? wdata_q : '0;
    assign mem_read  = busy & ~we_q;
    assign mem_write = final_cyc & (state == BUSY_D) & we_q;
    assign i_ready   = final_cyc & (state == BUSY_I);
    assign d_ready   = final_cyc & (state == BUSY_D);
    assign i_rdata   = i_ready ? mem_out : '0;
    assign d_rdata   = d_ready ? mem_out : '0;

endmodule
